// File: rtl/memory_arbiter.sv
// memory_arbiter: two-requester (instruction fetch / data) arbiter for a
// single-ported memory. One transaction outstanding, data priority bounded by
// a starvation counter, and a per-transaction timeout that completes with err.
module memory_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  // instruction fetch requester
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic              f_err,
  output logic [DATA_W-1:0] f_rdata,
  // data requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  // memory side
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int STV_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e              state_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [WAIT_W-1:0]   wait_d;
  logic [STV_W-1:0]    starve_q;
  logic [STV_W-1:0]    starve_d;
  logic                mem_valid_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic                grant_d_s;
  logic                grant_f_s;
  logic                busy_s;
  logic                timeout_s;
  logic                done_s;

  // Arbitration decision and completion detection for the current cycle.
  always_comb begin
    grant_d_s = 1'b0;
    grant_f_s = 1'b0;
    busy_s    = (state_q != IDLE);
    timeout_s = 1'b0;
    done_s    = 1'b0;
    if (state_q == IDLE) begin
      // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
      grant_d_s = d_req && (!f_req || (starve_q != STV_W'(STARVE_LIMIT)));
      grant_f_s = f_req && !grant_d_s;
    end else begin
      // A late mem_ready in the last allowed cycle still counts as success.
      timeout_s = !mem_ready && (wait_q == WAIT_W'(TIMEOUT - 1));
      done_s    = mem_ready || timeout_s;
    end
  end

  // Next values of the wait and starvation counters.
  always_comb begin
    wait_d   = wait_q;
    starve_d = starve_q;
    if (state_q == IDLE) begin
      wait_d = {WAIT_W{1'b0}};
      if (grant_d_s) begin
        // Cannot overflow: at the limit with f_req high, fetch is granted instead.
        if (f_req) begin
          starve_d = starve_q + STV_W'(1'b1);
        end else begin
          starve_d = {STV_W{1'b0}};
        end
      end else if (grant_f_s) begin
        starve_d = {STV_W{1'b0}};
      end else begin
        starve_d = starve_q;
      end
    end else if (!mem_ready) begin
      wait_d = wait_q + WAIT_W'(1'b1);
    end else begin
      wait_d = wait_q;
    end
  end

  // Main FSM: grant in IDLE, hold the memory bus while busy, release on completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_q      <= {WAIT_W{1'b0}};
      starve_q    <= {STV_W{1'b0}};
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
    end else begin
      wait_q   <= wait_d;
      starve_q <= starve_d;
      case (state_q)
        IDLE: begin
          if (grant_d_s) begin
            state_q     <= BUSY_D;
            mem_valid_q <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
          end else if (grant_f_s) begin
            state_q     <= BUSY_F;
            mem_valid_q <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= f_addr;
            mem_wdata_q <= {DATA_W{1'b0}};
          end else begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
          end
        end
        BUSY_F, BUSY_D: begin
          if (done_s) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
          end else begin
            state_q     <= state_q;
            mem_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Completion strobes and read data steering back to the owning requester.
  always_comb begin
    f_ack   = 1'b0;
    f_err   = 1'b0;
    f_rdata = {DATA_W{1'b0}};
    d_ack   = 1'b0;
    d_err   = 1'b0;
    d_rdata = {DATA_W{1'b0}};
    if (busy_s && done_s) begin
      if (state_q == BUSY_F) begin
        f_ack   = 1'b1;
        f_err   = timeout_s;
        f_rdata = mem_rdata;
      end else begin
        d_ack   = 1'b1;
        d_err   = timeout_s;
        d_rdata = mem_rdata;
      end
    end else begin
      f_ack = 1'b0;
      d_ack = 1'b0;
    end
  end

endmodule
